// File: rtl/sysid_info_slave.sv
// Purpose : Avalon-MM system-ID slave: ID/timestamp/info words, RW scratch, optional 64-bit uptime counter.
// Latency : readdata/readdatavalid appear READ_LATENCY (1..3) cycles after an accepted read.
// Backpr. : none; read and write are accepted every cycle, a read colliding with a write is dropped.
// Build   : define SYSID_UPTIME_EN to build the uptime counter, its shadow and the CTRL register.
module sysid_info_slave #(
    parameter logic [31:0] SYSID_ID     = 32'h0000_0000,
    parameter logic [31:0] SYSID_TS     = 32'h0000_0000,
    parameter logic [15:0] HW_VERSION   = 16'h0002,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    // Out-of-range latencies are flagged at elaboration; the pipeline is clamped so it still builds.
    localparam int          LAT       = (READ_LATENCY < 1) ? 1 : ((READ_LATENCY > 3) ? 3 : READ_LATENCY);
    localparam logic [31:0] RL_WORD   = READ_LATENCY;
    localparam logic [1:0]  LAT_FIELD = RL_WORD[1:0];

    if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
        $error("sysid_info_slave: READ_LATENCY must be in 1..3");
    end

`ifdef SYSID_UPTIME_EN
    localparam logic UPTIME_PRESENT = 1'b1;
`else
    localparam logic UPTIME_PRESENT = 1'b0;
`endif

    localparam logic [31:0] INFO = {HW_VERSION, 6'b0, UPTIME_PRESENT, 1'b1, 6'b0, LAT_FIELD};

    // A read in the same cycle as a write is discarded; the write wins.
    logic        rd_acc;
    logic [31:0] rd_mux;
    logic [31:0] scratch;

    assign rd_acc = read & ~write;

`ifdef SYSID_UPTIME_EN
    logic [63:0] uptime;
    // Only the high half of the snapshot is ever returned (address 5); the low half is
    // served live at address 4, which equals the snapshot value in that same cycle.
    logic [31:0] shadow_hi;
    logic        uptime_clr;

    assign uptime_clr = write && (address == 3'd6) && byteenable[0] && writedata[0];

    // Free-running uptime counter; a CTRL clear beats the increment.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            uptime <= '0;
        end else if (uptime_clr) begin
            uptime <= '0;
        end else begin
            uptime <= uptime + 64'd1;
        end
    end

    // Snapshot the counter (pre-increment value) when UPTIME_LO is read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow_hi <= '0;
        end else if (rd_acc && (address == 3'd4)) begin
            shadow_hi <= uptime[63:32];
        end
    end
`endif

    // Scratch register with per-byte write enables.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch <= '0;
        end else if (write && (address == 3'd3)) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    scratch[8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

    // Register map read mux; unmapped and write-only addresses read as zero.
    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0:    rd_mux = SYSID_ID;
            3'd1:    rd_mux = SYSID_TS;
            3'd2:    rd_mux = INFO;
            3'd3:    rd_mux = scratch;
`ifdef SYSID_UPTIME_EN
            3'd4:    rd_mux = uptime[31:0];
            3'd5:    rd_mux = shadow_hi;
`endif
            default: rd_mux = '0;
        endcase
    end

    // Read pipeline: data stages only load when a valid enters them, so the last
    // stage (the readdata register) holds its value between valids.
    logic [LAT-1:0] vld_sr;
    logic [31:0]    dat_sr [LAT];

    // First pipeline stage captures the data sampled in the accept cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_sr[0] <= 1'b0;
            dat_sr[0] <= '0;
        end else begin
            vld_sr[0] <= rd_acc;
            if (rd_acc) begin
                dat_sr[0] <= rd_mux;
            end
        end
    end

    for (genvar s = 1; s < LAT; s++) begin : g_stage
        // Further stages shift the valid and move data only alongside it.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                vld_sr[s] <= 1'b0;
                dat_sr[s] <= '0;
            end else begin
                vld_sr[s] <= vld_sr[s-1];
                if (vld_sr[s-1]) begin
                    dat_sr[s] <= dat_sr[s-1];
                end
            end
        end
    end

    assign readdatavalid = vld_sr[LAT-1];
    assign readdata      = dat_sr[LAT-1];

endmodule
